// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / write-back control,
// program counter, instruction register and retired-instruction counter.
module cpu_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic        dec_valid,
   input  logic        dec_regWrite,
   input  logic        dec_pcSrc,
   input  logic [31:0] imm_b,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [31:0] retired,
   output logic        busy,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_C = FETCH_TIMEOUT[7:0];

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic [7:0]  wait_q, wait_d;
   logic        regwrite_q, regwrite_d;
   logic        pcsrc_q, pcsrc_d;
   logic        imem_req_q, imem_req_d;
   logic        rf_we_q, rf_we_d;
   logic        busy_q, busy_d;
   logic        halted_q, halted_d;
   logic [31:0] next_pc_s;
   logic [7:0]  wait_inc_s;

   // Next-state and datapath-register computation for every sequencer state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      retired_d  = retired_q;
      wait_d     = wait_q;
      regwrite_d = regwrite_q;
      pcsrc_d    = pcsrc_q;
      wait_inc_s = wait_q + 8'd1;
      next_pc_s  = pc_q + (pcsrc_q ? imm_b : 32'd4);

      case (state_q)
         S_IDLE: begin
            if (run_en) begin
               state_d = S_FETCH;
               wait_d  = 8'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end else if (wait_inc_s == TIMEOUT_C) begin
               wait_d  = wait_inc_s;
               state_d = S_TRAP;
            end else begin
               wait_d  = wait_inc_s;
            end
         end
         S_DECODE: begin
            if (dec_valid) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_EXEC: begin
            regwrite_d = dec_regWrite;
            pcsrc_d    = dec_pcSrc;
            state_d    = S_WB;
         end
         S_WB: begin
            // A misaligned branch target halts without committing the instruction.
            if (pcsrc_q && (next_pc_s[1:0] != 2'b00)) begin
               state_d = S_TRAP;
            end else begin
               pc_d      = next_pc_s;
               retired_d = retired_q + 32'd1;
               if (run_en) begin
                  state_d = S_FETCH;
                  wait_d  = 8'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase

      // Outputs are registered from the next state so they track state_q exactly.
      imem_req_d = (state_d == S_FETCH);
      rf_we_d    = (state_d == S_WB) && regwrite_d;
      busy_d     = (state_d != S_IDLE) && (state_d != S_TRAP);
      halted_d   = (state_d == S_TRAP);
   end

   // Sequencer state, architectural registers and registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         retired_q  <= 32'd0;
         wait_q     <= 8'd0;
         regwrite_q <= 1'b0;
         pcsrc_q    <= 1'b0;
         imem_req_q <= 1'b0;
         rf_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         retired_q  <= retired_d;
         wait_q     <= wait_d;
         regwrite_q <= regwrite_d;
         pcsrc_q    <= pcsrc_d;
         imem_req_q <= imem_req_d;
         rf_we_q    <= rf_we_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign rf_we     = rf_we_q;
   assign pc        = pc_q;
   assign retired   = retired_q;
   assign busy      = busy_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-instruction transaction model drives
// memory/decoder responses with random noise and predicts pc, IR, retired and controls.
module tb_cpu_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TMO    = 16;

   logic        clk;
   logic        rst_n;
   logic        run_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        dec_valid;
   logic        dec_regWrite;
   logic        dec_pcSrc;
   logic [31:0] imm_b;
   logic        rf_we;
   logic [31:0] pc;
   logic [31:0] retired;
   logic        busy;
   logic        halted;

   int          n_checks;
   int          n_errors;
   logic [31:0] m_pc;
   logic [31:0] m_ret;
   logic [31:0] m_ir;

   cpu_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .run_en(run_en),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .dec_valid(dec_valid), .dec_regWrite(dec_regWrite), .dec_pcSrc(dec_pcSrc),
      .imm_b(imm_b), .rf_we(rf_we), .pc(pc), .retired(retired), .busy(busy), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic junk();
      dec_valid    = 1'($urandom);
      dec_regWrite = 1'($urandom);
      dec_pcSrc    = 1'($urandom);
      imm_b        = $urandom;
      imem_rdata   = $urandom;
   endtask

   task automatic ctl(input string ph, input logic er, input logic we, input logic bz, input logic hl);
      check({ph, ".imem_req"}, {31'd0, imem_req}, {31'd0, er});
      check({ph, ".rf_we"},    {31'd0, rf_we},    {31'd0, we});
      check({ph, ".busy"},     {31'd0, busy},     {31'd0, bz});
      check({ph, ".halted"},   {31'd0, halted},   {31'd0, hl});
   endtask

   task automatic arch(input string ph);
      check({ph, ".pc"},        pc,        m_pc);
      check({ph, ".imem_addr"}, imem_addr, m_pc);
      check({ph, ".retired"},   retired,   m_ret);
      check({ph, ".instr"},     instr,     m_ir);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_pc  = RST_PC;
      m_ret = 32'd0;
      m_ir  = 32'd0;
      ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
      arch("rst_async");
      run_en   = 1'b0;
      imem_ack = 1'b0;
      tick();
      ctl("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      ctl("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
      arch("rst_after");
   endtask

   task automatic start();
      junk();
      run_en = 1'b1;
      tick();
      ctl("start", 1'b1, 1'b0, 1'b1, 1'b0);
      arch("start");
   endtask

   task automatic trap_hold();
      for (int i = 0; i < 5; i++) begin
         junk();
         imem_ack = 1'($urandom);
         run_en   = 1'($urandom);
         tick();
         ctl("trap", 1'b0, 1'b0, 1'b0, 1'b1);
         arch("trap");
      end
   endtask

   // One instruction from FETCH entry to its WB decision; DUT must be in FETCH on entry.
   task automatic run_instr(input int delay, input bit valid, input bit rw, input bit br,
                            input logic [31:0] imm, input bit run_wb, output bit trapped);
      logic [31:0] word;
      logic [31:0] target;
      word = $urandom;
      for (int i = 0; i <= delay; i++) begin
         ctl("fetch", 1'b1, 1'b0, 1'b1, 1'b0);
         arch("fetch");
         junk();
         run_en   = 1'($urandom);
         imem_ack = (i == delay);
         if (i == delay) imem_rdata = word;
         tick();
      end
      m_ir = word;
      ctl("decode", 1'b0, 1'b0, 1'b1, 1'b0);
      arch("decode");
      junk();
      imem_ack  = 1'($urandom);
      run_en    = 1'($urandom);
      dec_valid = valid;
      tick();
      if (!valid) begin
         ctl("dec_trap", 1'b0, 1'b0, 1'b0, 1'b1);
         arch("dec_trap");
         imem_ack = 1'b0;
         trapped  = 1'b1;
         return;
      end
      ctl("exec", 1'b0, 1'b0, 1'b1, 1'b0);
      arch("exec");
      junk();
      imem_ack     = 1'($urandom);
      run_en       = 1'($urandom);
      dec_regWrite = rw;
      dec_pcSrc    = br;
      tick();
      ctl("wb", 1'b0, rw, 1'b1, 1'b0);
      arch("wb");
      junk();
      imem_ack = 1'($urandom);
      imm_b    = imm;
      run_en   = run_wb;
      tick();
      imem_ack = 1'b0;
      target = m_pc + (br ? imm : 32'd4);
      if (br && (target[1:0] != 2'b00)) begin
         ctl("br_trap", 1'b0, 1'b0, 1'b0, 1'b1);
         arch("br_trap");
         trapped = 1'b1;
      end else begin
         m_pc  = target;
         m_ret = m_ret + 32'd1;
         ctl("retire", run_wb, 1'b0, run_wb, 1'b0);
         arch("retire");
         trapped = 1'b0;
      end
   endtask

   initial begin
      bit          t;
      bit          br;
      bit          rw;
      bit          rwb;
      logic [31:0] imm;
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      run_en       = 1'b0;
      imem_ack     = 1'b0;
      imem_rdata   = 32'd0;
      dec_valid    = 1'b0;
      dec_regWrite = 1'b0;
      dec_pcSrc    = 1'b0;
      imm_b        = 32'd0;
      m_pc         = RST_PC;
      m_ret        = 32'd0;
      m_ir         = 32'd0;
      tick();
      ctl("por", 1'b0, 1'b0, 1'b0, 1'b0);
      arch("por");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         junk();
         imem_ack = 1'($urandom);
         tick();
         ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
         arch("idle");
      end
      imem_ack = 1'b0;

      // Directed: ADDI, delayed acks, taken BEQ backwards, not-taken BNE.
      start();
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      check("addi.pc", pc, 32'h4);
      check("addi.retired", retired, 32'd1);
      run_instr(3, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      run_instr(1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, t);
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      check("pre_beq.pc", pc, 32'h10);
      run_instr(0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, t);
      check("beq.pc", pc, 32'h8);
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      run_instr(2, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      run_instr(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b1, t);
      check("bne.pc", pc, 32'h14);
      run_instr(TMO - 1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);

      // Random instruction stream with occasional stops at WB.
      for (int n = 0; n < 40; n++) begin
         br  = 1'($urandom);
         rw  = br ? 1'b0 : 1'($urandom);
         imm = $urandom & 32'hFFFF_FFFC;
         rwb = ($urandom_range(0, 3) != 0);
         run_instr($urandom_range(0, 4), 1'b1, rw, br, imm, rwb, t);
         if (!rwb) begin
            for (int k = 0; k < 2; k++) begin
               junk();
               imem_ack = 1'($urandom);
               tick();
               ctl("stopped", 1'b0, 1'b0, 1'b0, 1'b0);
               arch("stopped");
            end
            imem_ack = 1'b0;
            start();
         end
      end

      // PC wrap at the top of the address space.
      run_instr(0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC - m_pc, 1'b1, t);
      check("wrap.pre_pc", pc, 32'hFFFF_FFFC);
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      check("wrap.pc", pc, 32'h0);

      // Reset while in EXEC with regWrite requested: no rf_we pulse.
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      tick();
      imem_ack  = 1'b0;
      dec_valid = 1'b1;
      tick();
      dec_regWrite = 1'b1;
      do_reset();
      start();
      check("post_rst.addr", imem_addr, RST_PC);

      // Decoder rejects the instruction.
      run_instr(0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, t);
      check("dec_trap.flag", {31'd0, t}, 32'd1);
      trap_hold();
      do_reset();

      // Misaligned taken branch.
      start();
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, t);
      run_instr(1, 1'b1, 1'b0, 1'b1, 32'd6, 1'b1, t);
      check("mis_trap.pc", pc, 32'h4);
      trap_hold();
      do_reset();

      // Fetch timeout.
      start();
      for (int i = 0; i < TMO; i++) begin
         ctl("tmo_wait", 1'b1, 1'b0, 1'b1, 1'b0);
         arch("tmo_wait");
         junk();
         run_en   = 1'($urandom);
         imem_ack = 1'b0;
         tick();
      end
      ctl("tmo", 1'b0, 1'b0, 1'b0, 1'b1);
      arch("tmo");
      trap_hold();
      do_reset();
      start();
      run_instr(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, t);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16: maximum FETCH cycles without imem_ack before trap; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run_en  input  1  1 = execute instructions; 0 = stop at the next instruction boundary.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  32  fetch address, always equal to pc.
REQ-008 imem_ack  input  1  fetch data valid on imem_rdata this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr  output  32  instruction register (IR), feeds decoder/datapath.
REQ-011 dec_valid  input  1  decoder recognised IR (ADD, OR, SRL, SLTU, SUB, ADDI, LUI, BEQ, BNE).
REQ-012 dec_regWrite  input  1  decoder register-write request.
REQ-013 dec_pcSrc  input  1  decoder branch-taken (branch & ALU zero condition).
REQ-014 imm_b  input  32  sign-extended branch offset from datapath.
REQ-015 rf_we  output  1  gated register-file write enable.
REQ-016 pc  output  32  program counter.
REQ-017 retired  output  32  retired-instruction counter.
REQ-018 busy  output  1  high in any state except IDLE and TRAP.
REQ-019 halted  output  1  high in TRAP.

Function
REQ-020 FSM states: IDLE, FETCH, DECODE, EXEC, WB, TRAP.
REQ-021 IDLE: run_en=1 -> FETCH; else stay.
REQ-022 FETCH: imem_req=1; imem_ack=1 -> IR<=imem_rdata, go DECODE; otherwise stay and increment the wait counter.
REQ-023 FETCH: wait counter reaching FETCH_TIMEOUT with imem_ack=0 -> TRAP; counter clears on FETCH entry.
REQ-024 imem_ack outside FETCH is ignored; IR changes only on an accepted fetch.
REQ-025 DECODE: one cycle; dec_valid=0 -> TRAP; else -> EXEC.
REQ-026 EXEC: one cycle; dec_regWrite and dec_pcSrc registered at end of EXEC; -> WB.
REQ-027 WB: rf_we = registered dec_regWrite, for exactly this one cycle; rf_we=0 in every other state.
REQ-028 WB: next pc = pc+imm_b if registered pcSrc, else pc+4; 32-bit add, wraps modulo 2^32.
REQ-029 WB: branch target with bits[1:0]!=0 -> TRAP; pc unchanged, retired unchanged, rf_we still per REQ-027 (branches never write).
REQ-030 WB: otherwise retired<=retired+1 (wraps 32'hFFFF_FFFF -> 0); run_en=1 -> FETCH, run_en=0 -> IDLE.
REQ-031 Minimum latency: 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC, WB).
REQ-032 run_en deassertion mid-instruction has no effect until the WB decision.
REQ-033 TRAP: imem_req=0, rf_we=0, pc/IR/retired frozen; exits only by reset.
REQ-034 imem_req, rf_we, busy, halted are decoded from state only (no input-to-output combinational path).

Reset
REQ-035 rst_n=0 asynchronously forces: state IDLE, pc=RESET_PC, instr=0, retired=0, wait counter=0, registered pcSrc/regWrite=0.
REQ-036 During and immediately after reset: imem_req=0, rf_we=0, busy=0, halted=0.
REQ-037 Reset asserted mid-instruction (any state, including TRAP) aborts it with no rf_we pulse; first fetch after release is at RESET_PC.

Verification
REQ-038 run_en=1, ack same cycle, ADDI (dec_valid=1, regWrite=1) -> rf_we high cycle 4 only, pc 0->4, retired 0->1.
REQ-039 BEQ taken, imm_b=32'hFFFF_FFF8, pc=0x10 -> rf_we=0, pc=0x08; BNE not taken -> pc=0x14.
REQ-040 ack delayed 3 cycles -> imem_req held 4 cycles, addr stable; no ack for 16 cycles -> halted=1, pc frozen.
REQ-041 dec_valid=0 in DECODE -> TRAP, no rf_we, retired unchanged; imm_b=6 taken -> TRAP, pc unchanged.
REQ-042 pc=32'hFFFF_FFFC non-branch -> pc=0; retired=32'hFFFF_FFFF after WB -> 0.
REQ-043 rst_n low in EXEC with regWrite=1 -> no rf_we pulse, pc=RESET_PC, state IDLE; run_en=0 at WB -> IDLE, busy=0.
